// File: rtl/lvt_pkg.sv
// Shared definitions for the LVT multi-ported RAM: width helpers and FSM states.
package lvt_pkg;

   // Ceiling log2; returns 0 for n <= 1.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

   // Width of one live-value-table entry; a single write port still needs one bit.
   function automatic int lvt_idx_w(input int nw);
      return (clog2(nw) < 1) ? 1 : clog2(nw);
   endfunction

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } lvt_state_e;

endpackage

// File: rtl/lvt_mpram_if.sv
// Bus bundle for lvt_mpram: flattened per-port write and read channels plus status.
interface lvt_mpram_if #(
   parameter int NW     = 2,
   parameter int NR     = 1,
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8
) ();

   logic [NW-1:0]        wr_en;
   logic [NW*ADDR_W-1:0] wr_addr;
   logic [NW*DATA_W-1:0] wr_data;
   logic [NR-1:0]        rd_en;
   logic [NR*ADDR_W-1:0] rd_addr;
   logic [NR*DATA_W-1:0] rd_data;
   logic [NR-1:0]        rd_valid;
   logic                 init_busy;

   modport master (
      output wr_en, wr_addr, wr_data, rd_en, rd_addr,
      input  rd_data, rd_valid, init_busy
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
      output rd_data, rd_valid, init_busy
   );

endinterface

// File: rtl/lvt_bank.sv
// One write / one read RAM bank with a registered, read-enabled output.
// A read and write to the same address on one edge returns the old contents.
module lvt_bank #(
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // Storage write; contents are not reset, the owner clears them explicitly.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Output register: holds between reads, cleared by reset so the read port starts at zero.
   always_ff @(posedge clk) begin
      if (!rst) rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/lvt_mpram.sv
// Multi-ported RAM from NW*NR 1W1R banks and a live value table that remembers
// which write port last touched each address. Self-clears after reset.
module lvt_mpram
   import lvt_pkg::*;
#(
   parameter int NW     = 2,
   parameter int NR     = 1,
   parameter int ADDR_W = 7,
   parameter int DATA_W = 8,
   parameter int BYPASS = 0
) (
   input logic         clk,
   input logic         rst,
   lvt_mpram_if.slave  bus
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam int LW    = lvt_idx_w(NW);

   lvt_state_e        state_q, state_d;
   logic [ADDR_W-1:0] clr_q, clr_d;
   logic              in_init;
   logic              run;

   logic [ADDR_W-1:0] wa [NW];
   logic [DATA_W-1:0] wd [NW];
   logic [ADDR_W-1:0] ra [NR];

   logic [NW-1:0]     bank_we;
   logic [ADDR_W-1:0] bank_wa [NW];
   logic [DATA_W-1:0] bank_wd [NW];
   logic [DATA_W-1:0] bank_q  [NW][NR];

   logic [LW-1:0]     lvt [DEPTH];

   logic [NR-1:0]     rd_fire;
   logic [NR-1:0]     hit;
   logic [DATA_W-1:0] hit_data [NR];
   logic [LW-1:0]     sel_q    [NR];
   logic [NR-1:0]     byp_q;
   logic [DATA_W-1:0] byp_d_q  [NR];
   logic [NR-1:0]     valid_q;
   logic [NR*DATA_W-1:0] rd_data_all;

   // Ports are ignored while reset is held so nothing leaks into the fresh clear.
   assign in_init = (state_q == ST_INIT);
   assign run     = (state_q == ST_RUN) && rst;
   assign rd_fire = {NR{run}} & bus.rd_en;

   for (genvar w = 0; w < NW; w++) begin : g_wr_unpack
      assign wa[w] = bus.wr_addr[w*ADDR_W +: ADDR_W];
      assign wd[w] = bus.wr_data[w*DATA_W +: DATA_W];
   end

   for (genvar r = 0; r < NR; r++) begin : g_rd_unpack
      assign ra[r] = bus.rd_addr[r*ADDR_W +: ADDR_W];
   end

   // State and clear-address register; reset always restarts the clear at address 0.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_INIT;
         clr_q   <= '0;
      end else begin
         state_q <= state_d;
         clr_q   <= clr_d;
      end
   end

   // Walk the clear address through every location, then hand over to normal operation.
   always_comb begin
      state_d = state_q;
      clr_d   = clr_q;
      case (state_q)
         ST_INIT: begin
            clr_d = clr_q + 1'b1;
            if (clr_q == {ADDR_W{1'b1}}) state_d = ST_RUN;
         end
         ST_RUN: begin
            state_d = ST_RUN;
         end
      endcase
   end

   assign bus.init_busy = in_init;

   // Bank write steering: the clear sequence owns every bank's write port during INIT.
   always_comb begin
      for (int w = 0; w < NW; w++) begin
         bank_we[w] = in_init | (run & bus.wr_en[w]);
         bank_wa[w] = in_init ? clr_q : wa[w];
         bank_wd[w] = in_init ? '0 : wd[w];
      end
   end

   for (genvar w = 0; w < NW; w++) begin : g_wr
      for (genvar r = 0; r < NR; r++) begin : g_rd
         lvt_bank #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W)
         ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .we    (bank_we[w]),
            .waddr (bank_wa[w]),
            .wdata (bank_wd[w]),
            .re    (rd_fire[r]),
            .raddr (ra[r]),
            .rdata (bank_q[w][r])
         );
      end
   end

   // Live value table update; ascending port order lets the highest enabled port win a tie.
   always_ff @(posedge clk) begin
      if (in_init) begin
         lvt[clr_q] <= '0;
      end else if (run) begin
         for (int w = 0; w < NW; w++) begin
            if (bus.wr_en[w]) lvt[wa[w]] <= LW'(w);
         end
      end
   end

   // Same-cycle write match per read port, again letting the highest port index win.
   always_comb begin
      for (int r = 0; r < NR; r++) begin
         hit[r]      = 1'b0;
         hit_data[r] = '0;
         for (int w = 0; w < NW; w++) begin
            if (bus.wr_en[w] && (wa[w] == ra[r])) begin
               hit[r]      = 1'b1;
               hit_data[r] = wd[w];
            end
         end
      end
   end

   // Read bookkeeping captured alongside the bank read: which bank to show, or the bypassed word.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int r = 0; r < NR; r++) begin
            sel_q[r]   <= '0;
            byp_d_q[r] <= '0;
         end
         byp_q   <= '0;
         valid_q <= '0;
      end else begin
         valid_q <= rd_fire;
         for (int r = 0; r < NR; r++) begin
            if (rd_fire[r]) begin
               sel_q[r]   <= lvt[ra[r]];
               byp_q[r]   <= (BYPASS != 0) && hit[r];
               byp_d_q[r] <= hit_data[r];
            end
         end
      end
   end

   // Output select from registered state only, so rd_data holds whenever no read fires.
   always_comb begin
      rd_data_all = '0;
      for (int r = 0; r < NR; r++) begin
         rd_data_all[r*DATA_W +: DATA_W] = byp_q[r] ? byp_d_q[r] : bank_q[sel_q[r]][r];
      end
   end

   assign bus.rd_data  = rd_data_all;
   assign bus.rd_valid = valid_q;

endmodule
